// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Latency: fixed 34 cycles from the accepting start edge to the done pulse, for every op.
// Backpressure: none; busy is high while in flight and start is ignored unless idle.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start, flush    request strobe (sampled in IDLE only) / synchronous abort
//   alu_ctrl        5-bit operation code shared with the ALU decoder
//   op_a, op_b      rs1 / rs2 operands
//   busy            operation in flight (CALC or FINISH), registered state decode
//   done, result    one-cycle completion pulse; result held until the next completion
module muldiv_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALUCTR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_WIDTH-1:0]   result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    localparam logic [ALUCTR_WIDTH-1:0] OP_MUL    = ALUCTR_WIDTH'(5'b01010);
    localparam logic [ALUCTR_WIDTH-1:0] OP_MULH   = ALUCTR_WIDTH'(5'b01011);
    localparam logic [ALUCTR_WIDTH-1:0] OP_MULHSU = ALUCTR_WIDTH'(5'b01100);
    localparam logic [ALUCTR_WIDTH-1:0] OP_MULHU  = ALUCTR_WIDTH'(5'b01101);
    localparam logic [ALUCTR_WIDTH-1:0] OP_DIV    = ALUCTR_WIDTH'(5'b01110);
    localparam logic [ALUCTR_WIDTH-1:0] OP_DIVU   = ALUCTR_WIDTH'(5'b01111);
    localparam logic [ALUCTR_WIDTH-1:0] OP_REM    = ALUCTR_WIDTH'(5'b10000);
    localparam logic [ALUCTR_WIDTH-1:0] OP_REMU   = ALUCTR_WIDTH'(5'b10001);

    localparam logic [W-1:0] SIGNED_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Latched operation context
    logic [ALUCTR_WIDTH-1:0] op_q;
    logic [W-1:0]            a_raw_q;   // original op_a, returned by REM/REMU on divide-by-zero
    logic [W-1:0]            m_q;       // multiplicand magnitude (mul) or divisor magnitude (div)
    logic                    a_neg_q;
    logic                    b_neg_q;
    logic [CW-1:0]           cnt_q;

    // Shared working pair. Multiply: {hi,lo} is the product with the multiplier
    // shifting out of lo. Divide: hi is the partial remainder, lo shifts the
    // dividend out and the quotient in.
    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    // ------------------------------------------------------------------
    // Incoming operation decode
    // ------------------------------------------------------------------
    logic         code_ok;
    logic         is_mul_in;
    logic         sign_a_in;
    logic         sign_b_in;
    logic         a_neg_in;
    logic         b_neg_in;
    logic [W-1:0] mag_a_in;
    logic [W-1:0] mag_b_in;
    logic         accept;

    always_comb begin
        is_mul_in = (alu_ctrl == OP_MUL)  || (alu_ctrl == OP_MULH) ||
                    (alu_ctrl == OP_MULHSU) || (alu_ctrl == OP_MULHU);
        code_ok   = is_mul_in ||
                    (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU) ||
                    (alu_ctrl == OP_REM) || (alu_ctrl == OP_REMU);
        sign_a_in = (alu_ctrl == OP_MULH) || (alu_ctrl == OP_MULHSU) ||
                    (alu_ctrl == OP_DIV)  || (alu_ctrl == OP_REM);
        sign_b_in = (alu_ctrl == OP_MULH) || (alu_ctrl == OP_DIV) ||
                    (alu_ctrl == OP_REM);
        a_neg_in  = sign_a_in && op_a[W-1];
        b_neg_in  = sign_b_in && op_b[W-1];
        mag_a_in  = a_neg_in ? (~op_a + 1'b1) : op_a;
        mag_b_in  = b_neg_in ? (~op_b + 1'b1) : op_b;
        accept    = (state == S_IDLE) && start && code_ok && !flush;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start && code_ok) state_nxt = S_CALC;
            S_CALC:   if (cnt_q == CNT_LAST) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic         op_is_mul;
    logic [W:0]   mul_sum;
    logic [W:0]   div_part;
    logic [W:0]   div_diff;
    logic         div_ge;
    logic [W-1:0] step_hi;
    logic [W-1:0] step_lo;

    always_comb begin
        op_is_mul = (op_q == OP_MUL)    || (op_q == OP_MULH) ||
                    (op_q == OP_MULHSU) || (op_q == OP_MULHU);

        // Add the multiplicand when the outgoing multiplier bit is set, then
        // shift the 65-bit {carry,hi,lo} right by one.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(W+1){1'b0}});

        // Bring the next dividend bit into the remainder and try a subtract.
        // The partial is below 2*divisor, so the difference fits W bits.
        div_part = {hi_q, lo_q[W-1]};
        div_diff = div_part - {1'b0, m_q};
        div_ge   = (div_part >= {1'b0, m_q});

        if (op_is_mul) begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo_q[W-1:1]};
        end else begin
            step_hi = div_ge ? div_diff[W-1:0] : div_part[W-1:0];
            step_lo = {lo_q[W-2:0], div_ge};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_raw_q <= '0;
            m_q     <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (accept) begin
                        op_q    <= alu_ctrl;
                        a_raw_q <= op_a;
                        a_neg_q <= a_neg_in;
                        b_neg_q <= b_neg_in;
                        hi_q    <= '0;
                        if (is_mul_in) begin
                            m_q  <= mag_a_in;
                            lo_q <= mag_b_in;
                        end else begin
                            m_q  <= mag_b_in;
                            lo_q <= mag_a_in;
                        end
                    end
                end
                S_CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FINISH: sign correction and special cases
    // ------------------------------------------------------------------
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s;
    logic [W-1:0]   rem_s;
    logic           div_zero;
    logic           div_ovf;
    logic [W-1:0]   fin_val;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_s   = (a_neg_q ^ b_neg_q) ? (~prod + 1'b1) : prod;
        quot_s   = (a_neg_q ^ b_neg_q) ? (~lo_q + 1'b1) : lo_q;
        rem_s    = a_neg_q ? (~hi_q + 1'b1) : hi_q;
        // m_q is the divisor magnitude: zero iff the divisor is zero, and
        // magnitude one with a negative sign means -1.
        div_zero = (m_q == '0);
        div_ovf  = (a_raw_q == SIGNED_MIN) && b_neg_q && (m_q == W'(1));

        fin_val = '0;
        case (op_q)
            OP_MUL:    fin_val = prod_s[W-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fin_val = prod_s[2*W-1:W];
            OP_DIV:    fin_val = div_zero ? '1 : (div_ovf ? SIGNED_MIN : quot_s);
            OP_DIVU:   fin_val = div_zero ? '1 : lo_q;
            OP_REM:    fin_val = div_zero ? a_raw_q : (div_ovf ? '0 : rem_s);
            OP_REMU:   fin_val = div_zero ? a_raw_q : hi_q;
            default:   fin_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state == S_FINISH) && !flush) begin
                result <= fin_val;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [4:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests  = 0;
    int failed = 0;

    localparam logic [4:0] C_ADD    = 5'b00000;
    localparam logic [4:0] C_MUL    = 5'b01010;
    localparam logic [4:0] C_MULH   = 5'b01011;
    localparam logic [4:0] C_MULHSU = 5'b01100;
    localparam logic [4:0] C_MULHU  = 5'b01101;
    localparam logic [4:0] C_DIV    = 5'b01110;
    localparam logic [4:0] C_DIVU   = 5'b01111;
    localparam logic [4:0] C_REM    = 5'b10000;
    localparam logic [4:0] C_REMU   = 5'b10001;

    muldiv_unit #(
        .DATA_WIDTH   (32),
        .ALUCTR_WIDTH (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge. Drives an op, then checks busy
    // for cycles N+1..N+33, done/result at N+34, and optionally done low at N+35.
    // With poke set, a second start (DIVU 100/7) is driven during CALC.
    task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag,
                         input bit tail, input bit poke);
        int busy_cnt;
        int early;
        start    = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        tick();
        start    = 1'b0;
        alu_ctrl = C_ADD;
        op_a     = 32'hDEADBEEF;
        op_b     = 32'h12345678;
        busy_cnt = 0;
        early    = 0;
        for (int i = 1; i <= 33; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) early++;
            if (poke && i == 5) begin
                start    = 1'b1;
                alu_ctrl = C_DIVU;
                op_a     = 32'd100;
                op_b     = 32'd7;
            end else begin
                start    = 1'b0;
                alu_ctrl = C_ADD;
            end
            tick();
        end
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd33);
        chk({tag, " early_done"}, 32'(early), 32'd0);
        chk({tag, " done@34"}, {31'd0, done}, 32'd1);
        chk({tag, " busy@34"}, {31'd0, busy}, 32'd0);
        chk({tag, " result"}, result, exp);
        if (tail) begin
            tick();
            chk({tag, " done@35"}, {31'd0, done}, 32'd0);
        end
    endtask

    // Waits n cycles and returns how many had busy or done high.
    task automatic quiet(input int n, output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (busy !== 1'b0) busy_cnt++;
            if (done !== 1'b0) done_cnt++;
        end
    endtask

    initial begin
        int bc;
        int dc;
        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        alu_ctrl = C_ADD;
        op_a     = '0;
        op_b     = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        tick();

        // Multiply
        do_op(C_MUL,    32'd7,        32'd6,        32'd42,       "MUL 7x6", 1'b1, 1'b0);
        do_op(C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "MULH -1x-1", 1'b1, 1'b0);
        do_op(C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU max", 1'b1, 1'b0);
        do_op(C_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, "MULHSU -1x2", 1'b1, 1'b0);
        do_op(C_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, "MUL -3x5", 1'b1, 1'b0);

        // Divide
        do_op(C_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "DIV -7/2", 1'b1, 1'b0);
        do_op(C_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "REM -7/2", 1'b1, 1'b0);
        do_op(C_DIVU, 32'd100,      32'd7, 32'd14,       "DIVU 100/7", 1'b1, 1'b0);
        do_op(C_REMU, 32'd100,      32'd7, 32'd2,        "REMU 100/7", 1'b1, 1'b0);

        // Special cases
        do_op(C_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, "DIV 5/0", 1'b1, 1'b0);
        do_op(C_REMU, 32'd5,        32'd0,        32'd5,        "REMU 5/0", 1'b1, 1'b0);
        do_op(C_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, "DIVU 5/0", 1'b1, 1'b0);
        do_op(C_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, "REM -5/0", 1'b1, 1'b0);
        do_op(C_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV ovf", 1'b1, 1'b0);
        do_op(C_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, "REM ovf", 1'b1, 1'b0);

        // Non-muldiv code is ignored
        start    = 1'b1;
        alu_ctrl = C_ADD;
        op_a     = 32'd3;
        op_b     = 32'd4;
        tick();
        start = 1'b0;
        chk("ADD busy next", {31'd0, busy}, 32'd0);
        quiet(40, bc, dc);
        chk("ADD busy cycles", 32'(bc), 32'd0);
        chk("ADD done cycles", 32'(dc), 32'd0);
        chk("ADD result held", result, 32'h00000000);

        // Start during CALC is ignored; only one completion with the first result
        do_op(C_MUL, 32'd7, 32'd6, 32'd42, "MUL poked", 1'b1, 1'b1);
        quiet(40, bc, dc);
        chk("poke extra done", 32'(dc), 32'd0);

        // Flush in cycle N+10 of a divide
        start    = 1'b1;
        alu_ctrl = C_DIV;
        op_a     = 32'd100;
        op_b     = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy@11", {31'd0, busy}, 32'd0);
        chk("flush done@11", {31'd0, done}, 32'd0);
        quiet(40, bc, dc);
        chk("flush done cycles", 32'(dc), 32'd0);
        chk("flush result held", result, 32'd42);

        // Flush wins over start in the same cycle
        start    = 1'b1;
        flush    = 1'b1;
        alu_ctrl = C_MUL;
        op_a     = 32'd9;
        op_b     = 32'd9;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush>start busy", {31'd0, busy}, 32'd0);
        quiet(40, bc, dc);
        chk("flush>start done cycles", 32'(dc), 32'd0);

        // Back-to-back: second start issued in the first op's done cycle
        do_op(C_MULHU, 32'h00010000, 32'h00010000, 32'h00000001, "B2B first", 1'b0, 1'b0);
        do_op(C_DIVU,  32'd1000,     32'd10,       32'd100,      "B2B second", 1'b1, 1'b0);

        // Reset during CALC clears everything
        start    = 1'b1;
        alu_ctrl = C_MUL;
        op_a     = 32'd3;
        op_b     = 32'd3;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid busy", {31'd0, busy}, 32'd0);
        chk("rst mid result", result, 32'd0);
        quiet(40, bc, dc);
        chk("rst mid done cycles", 32'(dc), 32'd0);

        do_op(C_REMU, 32'd1000, 32'd7, 32'd6, "after rst REMU", 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execution unit for the RV32M instructions. Sits in the execute stage beside the single-cycle ALU and consumes the same 5-bit `alu_ctrl` code the ALU decoder produces. Accepts an operation via a start strobe, computes over a fixed 34-cycle latency while asserting `busy` so the hazard unit can stall the pipeline, and returns a registered 32-bit result with a one-cycle `done` pulse.

## Interface
- `DATA_WIDTH`, 32, operand and result width
- `ALUCTR_WIDTH`, 5, width of `alu_ctrl`
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: request; sampled only in IDLE
- `flush` in 1: synchronous abort of the in-flight operation
- `alu_ctrl` in ALUCTR_WIDTH: operation code (encodings below)
- `op_a` in DATA_WIDTH: rs1 value (multiplicand / dividend)
- `op_b` in DATA_WIDTH: rs2 value (multiplier / divisor)
- `busy` out 1: operation in flight (CALC or FINISH)
- `done` out 1: one-cycle pulse; `result` valid in the same cycle
- `result` out DATA_WIDTH: last completed result, held until the next completion

## Operation
- Codes: 01010 MUL, 01011 MULH, 01100 MULHSU, 01101 MULHU, 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
- Accept: IDLE and `start`=1 and code in the list above. Latch `alu_ctrl`, `op_a`, `op_b`, operand signs and magnitudes. Go to CALC with the iteration counter at 0.
- `start` with any other code, or while not IDLE: ignored. No state change.
- States: IDLE -> CALC on accept. CALC -> FINISH when the counter reaches 31 (32 iterations). FINISH -> IDLE always.
- Multiply: radix-2 shift-add on unsigned magnitudes into a 64-bit product.
  - Signed operand: op_a for MULH/MULHSU; op_b for MULH only. MUL sign handling is irrelevant to the low half.
  - FINISH negates the 64-bit product if the operand signs differ.
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
- Divide: radix-2 restoring division on magnitudes, one quotient bit per CALC cycle.
  - DIV/REM use signed magnitudes. FINISH applies sign correction: quotient negative iff signs differ; remainder takes the dividend's sign.
  - DIVU/REMU use the raw operands.
- Special cases, resolved in FINISH with no latency change:
  - Divisor 0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return `op_a`.
  - Overflow, DIV 0x80000000 / 0xFFFFFFFF: returns 0x80000000; REM returns 0.
- FINISH registers `result` and asserts `done` for the following cycle.
- `flush`: from any state go to IDLE next cycle. `done` is not asserted, `result` is unchanged, and the counter clears. `flush` takes priority over `start` in the same cycle, so no accept occurs.
- `rst`: all state cleared, same priority as `flush` and above it.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- Accept at cycle N: `busy`=1 in cycles N+1..N+33 (32 CALC cycles + FINISH).
- `done`=1 and new `result` in cycle N+34; `busy`=0 in that cycle. Fixed latency of 34 for every op, including the special cases.
- A new `start` is accepted in cycle N+34 itself (state is IDLE). Its `done` arrives at N+68.
- `busy` is a registered output (state != IDLE), with no combinational path from `start`.
- `done` is registered and is never high for two consecutive cycles.
- `rst` or `flush` during CALC: `busy`=0 next cycle; no `done` for the aborted op.

## Test plan
- Reset, then MUL 7 x 6 started at cycle 0 -> `busy` high cycles 1-33, `done` at cycle 34 with `result`=42; `done` low at 35.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -7 / 2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000, REM -> 0. All with `done` at exactly +34.
- `start` with code 00000 (ADD) -> `busy` stays 0, no `done`. `start` asserted during CALC -> ignored, and the first op's result is unchanged.
- `flush` at cycle 10 of DIV -> `busy`=0 at cycle 11, no `done`, prior `result` retained. Back-to-back: new start in the `done` cycle completes 34 cycles later.
